// File: rtl/ai_target_select.sv
// ai_target_select: scans the 10x10 density map one cell per clock, keeps the
// densest unfired cell overall and the densest unfired checkerboard cell, and
// returns the chosen shot over a valid/ready handshake.
module ai_target_select #(
  parameter int unsigned CELLS = 100,
  parameter int unsigned DW    = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CELLS*DW-1:0]   density,
  input  logic [CELLS-1:0]      fired,
  input  logic                  parity_en,
  output logic                  busy,
  output logic                  shot_valid,
  input  logic                  shot_ready,
  output logic [6:0]            shot_idx,
  output logic [3:0]            shot_row,
  output logic [3:0]            shot_col,
  output logic                  no_target
);

  localparam int unsigned IW       = 7;
  localparam int unsigned RW       = 4;
  localparam int unsigned COLS     = 10;
  localparam int unsigned LAST     = CELLS - 1;
  localparam int unsigned IDX_NONE = 127;
  localparam int unsigned RC_NONE  = 15;
  localparam int unsigned DBW      = $clog2(CELLS * DW);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [RW-1:0]   row_q, row_d, col_q, col_d;

  logic            a_vld_q, a_vld_d, p_vld_q, p_vld_d;
  logic [IW-1:0]   a_idx_q, a_idx_d, p_idx_q, p_idx_d;
  logic [RW-1:0]   a_row_q, a_row_d, p_row_q, p_row_d;
  logic [RW-1:0]   a_col_q, a_col_d, p_col_q, p_col_d;
  logic [DW-1:0]   a_den_q, a_den_d, p_den_q, p_den_d;

  logic            busy_q, busy_d, valid_q, valid_d, nt_q, nt_d;
  logic [IW-1:0]   sidx_q, sidx_d;
  logic [RW-1:0]   srow_q, srow_d, scol_q, scol_d;

  logic [DBW-1:0]  bit_base;
  logic [DW-1:0]   cur_den;
  logic            cur_elig, cur_par, take_a, take_p;

  // Evaluate the cell under the scan pointer against both running bests
  always_comb begin
    bit_base = DBW'(idx_q) * DBW'(DW);
    cur_den  = density[bit_base +: DW];
    cur_elig = !fired[idx_q];
    cur_par  = (row_q[0] == col_q[0]);
    take_a   = cur_elig && (!a_vld_q || (cur_den > a_den_q));
    take_p   = cur_elig && cur_par && (!p_vld_q || (cur_den > p_den_q));
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    a_vld_d = a_vld_q;
    a_idx_d = a_idx_q;
    a_row_d = a_row_q;
    a_col_d = a_col_q;
    a_den_d = a_den_q;
    p_vld_d = p_vld_q;
    p_idx_d = p_idx_q;
    p_row_d = p_row_q;
    p_col_d = p_col_q;
    p_den_d = p_den_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    nt_d    = nt_q;
    sidx_d  = sidx_q;
    srow_d  = srow_q;
    scol_d  = scol_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          a_vld_d = 1'b0;
          p_vld_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        if (take_a) begin
          a_vld_d = 1'b1;
          a_idx_d = idx_q;
          a_row_d = row_q;
          a_col_d = col_q;
          a_den_d = cur_den;
        end
        if (take_p) begin
          p_vld_d = 1'b1;
          p_idx_d = idx_q;
          p_row_d = row_q;
          p_col_d = col_q;
          p_den_d = cur_den;
        end
        if (idx_q == IW'(LAST)) begin
          // Choose from the bests including the final cell just evaluated
          state_d = HOLD;
          valid_d = 1'b1;
          nt_d    = 1'b0;
          if (parity_en && p_vld_d) begin
            sidx_d = p_idx_d;
            srow_d = p_row_d;
            scol_d = p_col_d;
          end else if (a_vld_d) begin
            sidx_d = a_idx_d;
            srow_d = a_row_d;
            scol_d = a_col_d;
          end else begin
            nt_d   = 1'b1;
            sidx_d = IW'(IDX_NONE);
            srow_d = RW'(RC_NONE);
            scol_d = RW'(RC_NONE);
          end
        end else begin
          idx_d = idx_q + IW'(1);
          if (col_q == RW'(COLS - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + RW'(1);
          end
        end
      end
      HOLD: begin
        if (valid_q && shot_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      a_vld_q <= 1'b0;
      a_idx_q <= '0;
      a_row_q <= '0;
      a_col_q <= '0;
      a_den_q <= '0;
      p_vld_q <= 1'b0;
      p_idx_q <= '0;
      p_row_q <= '0;
      p_col_q <= '0;
      p_den_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      nt_q    <= 1'b0;
      sidx_q  <= '0;
      srow_q  <= '0;
      scol_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      a_vld_q <= a_vld_d;
      a_idx_q <= a_idx_d;
      a_row_q <= a_row_d;
      a_col_q <= a_col_d;
      a_den_q <= a_den_d;
      p_vld_q <= p_vld_d;
      p_idx_q <= p_idx_d;
      p_row_q <= p_row_d;
      p_col_q <= p_col_d;
      p_den_q <= p_den_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      nt_q    <= nt_d;
      sidx_q  <= sidx_d;
      srow_q  <= srow_d;
      scol_q  <= scol_d;
    end
  end

  assign busy       = busy_q;
  assign shot_valid = valid_q;
  assign no_target  = nt_q;
  assign shot_idx   = sidx_q;
  assign shot_row   = srow_q;
  assign shot_col   = scol_q;

endmodule

// File: tb/tb_ai_target_select.sv
// Bench for ai_target_select: a reference model derived from the selection
// rules is compared with the DUT every cycle; directed scans pin the model.
module tb_ai_target_select;

  localparam int CELLS = 100;
  localparam int DW    = 6;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                parity_en = 1'b0;
  logic                shot_ready = 1'b0;
  logic [CELLS*DW-1:0] density = '0;
  logic [CELLS-1:0]    fired = '0;
  logic                busy, shot_valid, no_target;
  logic [6:0]          shot_idx;
  logic [3:0]          shot_row, shot_col;

  int n_tests = 0;
  int n_fail  = 0;

  ai_target_select #(.CELLS(CELLS), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .density(density),
    .fired(fired), .parity_en(parity_en), .busy(busy),
    .shot_valid(shot_valid), .shot_ready(shot_ready), .shot_idx(shot_idx),
    .shot_row(shot_row), .shot_col(shot_col), .no_target(no_target)
  );

  always #5 clk = ~clk;

  function automatic int den_of(int i);
    return int'(density[i*DW +: DW]);
  endfunction

  // Densest unfired cell (lowest index on ties), parity cells first if enabled
  function automatic int ref_pick();
    int best_a = -1;
    int best_p = -1;
    for (int i = 0; i < CELLS; i++) begin
      if (!fired[i]) begin
        if (best_a < 0 || den_of(i) > den_of(best_a)) best_a = i;
        if (((i / 10 + i % 10) % 2) == 0 && (best_p < 0 || den_of(i) > den_of(best_p)))
          best_p = i;
      end
    end
    if (parity_en && best_p >= 0) return best_p;
    return best_a;
  endfunction

  // Reference model: idle / 100-cycle scan / hold until accepted
  int   m_phase = 0;
  int   m_cnt   = 0;
  logic m_busy  = 1'b0;
  logic m_valid = 1'b0;
  logic m_nt    = 1'b0;
  int   m_idx   = 0;
  int   m_row   = 0;
  int   m_col   = 0;

  always @(posedge clk or negedge rst_n) begin : mdl
    int p;
    if (!rst_n) begin
      m_phase <= 0; m_cnt <= 0; m_busy <= 1'b0; m_valid <= 1'b0;
      m_nt <= 1'b0; m_idx <= 0; m_row <= 0; m_col <= 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase <= 1; m_cnt <= 0; m_busy <= 1'b1;
        end
        1: begin
          if (m_cnt == CELLS - 1) begin
            p = ref_pick();
            m_phase <= 2;
            m_valid <= 1'b1;
            if (p < 0) begin
              m_nt <= 1'b1; m_idx <= 127; m_row <= 15; m_col <= 15;
            end else begin
              m_nt <= 1'b0; m_idx <= p; m_row <= p / 10; m_col <= p % 10;
            end
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
        default: if (shot_ready) begin
          m_phase <= 0; m_valid <= 1'b0; m_busy <= 1'b0;
        end
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    n_tests++;
    if (busy !== m_busy || shot_valid !== m_valid || no_target !== m_nt ||
        int'(shot_idx) != m_idx || int'(shot_row) != m_row || int'(shot_col) != m_col) begin
      n_fail++;
      if (n_fail < 40)
        $display("FAIL cycle@%0t: got busy=%0b vld=%0b nt=%0b idx=%0d r=%0d c=%0d, expected busy=%0b vld=%0b nt=%0b idx=%0d r=%0d c=%0d",
                 $time, busy, shot_valid, no_target, shot_idx, shot_row, shot_col,
                 m_busy, m_valid, m_nt, m_idx, m_row, m_col);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_den(input int i, input int v);
    density[i*DW +: DW] = DW'(v);
  endtask

  task automatic fill_den(input int v);
    for (int i = 0; i < CELLS; i++) set_den(i, v);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!shot_valid && cyc < 300) begin
      tick(1);
      cyc++;
    end
    if (!shot_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic accept();
    shot_ready = 1'b1;
    tick(1);
    shot_ready = 1'b0;
    chk("valid_drop", int'(shot_valid), 0);
    chk("busy_drop", int'(busy), 0);
  endtask

  // Full scan with literal expectations on the result
  task automatic scan(input string name, input int e_idx, input int e_row,
                      input int e_col, input int e_nt);
    int c;
    do_start();
    wait_valid(c);
    chk({name, "_latency"}, c, 100);
    chk({name, "_idx"}, int'(shot_idx), e_idx);
    chk({name, "_row"}, int'(shot_row), e_row);
    chk({name, "_col"}, int'(shot_col), e_col);
    chk({name, "_nt"}, int'(no_target), e_nt);
    accept();
  endtask

  initial begin
    int c, saved, p, mode;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(shot_valid), 0);
    chk("rst_idx", int'(shot_idx), 0);
    chk("rst_row", int'(shot_row), 0);

    // Reset mid-scan, then a clean scan
    fill_den(2);
    set_den(63, 63);
    do_start();
    tick(40);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(shot_valid), 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    scan("after_rst", 63, 6, 3, 0);

    // Single peak
    fill_den(1);
    set_den(57, 20);
    scan("peak", 57, 5, 7, 0);

    // Tie with the lower cell fired, then unfired
    fill_den(5);
    set_den(12, 30);
    set_den(34, 30);
    fired[12] = 1'b1;
    scan("tie_fired", 34, 3, 4, 0);
    fired[12] = 1'b0;
    scan("tie_low", 12, 1, 2, 0);

    // Parity preference and fallback
    fill_den(0);
    set_den(1, 40);
    set_den(0, 10);
    parity_en = 1'b1;
    scan("parity", 0, 0, 0, 0);
    for (int i = 0; i < CELLS; i++)
      if (((i / 10 + i % 10) % 2) == 0) fired[i] = 1'b1;
    scan("parity_fb", 1, 0, 1, 0);

    // Nothing left to shoot
    fired = '1;
    scan("none", 127, 15, 15, 1);

    // Held result with starts ignored while busy and at the handshake
    fired = '0;
    parity_en = 1'b0;
    for (int i = 0; i < CELLS; i++) set_den(i, int'($urandom_range(0, 63)));
    do_start();
    wait_valid(c);
    chk("hs_latency", c, 100);
    saved = int'(shot_idx);
    chk("hs_idx", saved, ref_pick());
    for (int k = 0; k < 20; k++) begin
      start = (k == 5);
      tick(1);
    end
    start = 1'b0;
    chk("hs_stable", int'(shot_idx), saved);
    chk("hs_still_valid", int'(shot_valid), 1);
    start = 1'b1;
    shot_ready = 1'b1;
    tick(1);
    start = 1'b0;
    shot_ready = 1'b0;
    tick(2);
    chk("hs_start_ignored", int'(busy), 0);
    set_den(99, 63);
    p = ref_pick();
    scan("hs_second", p, p / 10, p % 10, 0);

    // Randomised scans
    for (int t = 0; t < 30; t++) begin
      mode = int'($urandom_range(0, 3));
      for (int i = 0; i < CELLS; i++)
        set_den(i, int'(mode == 0 ? $urandom_range(0, 3) : $urandom_range(0, 63)));
      if (mode == 1) begin
        fired = '1;
        for (int k = 0; k < 3; k++) fired[$urandom_range(0, CELLS-1)] = 1'b0;
      end else if (mode == 3) begin
        fired = '0;
      end else begin
        for (int i = 0; i < CELLS; i++) fired[i] = ($urandom_range(0, 3) == 0);
      end
      parity_en = 1'($urandom_range(0, 1));
      do_start();
      if (t % 3 == 0) shot_ready = 1'b1;
      wait_valid(c);
      chk("rnd_latency", c, 100);
      if (t % 3 == 0) begin
        tick(1);
        shot_ready = 1'b0;
        chk("rnd_early_drop", int'(shot_valid), 0);
      end else begin
        tick(int'($urandom_range(0, 5)));
        accept();
      end
      tick(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ai_target_select.md
Name: ai_target_select

Overview:
- Consumer of the AI density map: takes the 100-cell density map (6 bits per cell) and the fired mask, and picks the next cell the AI fires on.
- Scans the board one cell per clock and keeps the best eligible cell.
- Returns the result as a shot index plus row/column over a valid/ready handshake to the game controller.
- Sits between the density generator and the shot-issue logic.

Parameters:
- CELLS, 100, number of board cells (10x10, index = row*10 + col).
- DW, 6, density width per cell.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a scan; honoured only in IDLE.
- density  in  CELLS*DW (600)  flattened map; cell i occupies bits [i*6+5 : i*6].
- fired  in  CELLS (100)  1 = cell already shot; not a candidate.
- parity_en  in  1  prefer checkerboard cells, i.e. (row+col) even.
- busy  out  1  high in SCAN and HOLD.
- shot_valid  out  1  result available (HOLD state).
- shot_ready  in  1  consumer accepts the result.
- shot_idx  out  7  chosen cell 0..99; 127 when no_target.
- shot_row  out  4  shot_idx/10; 15 when no_target.
- shot_col  out  4  shot_idx%10; 15 when no_target.
- no_target  out  1  valid with shot_valid; every cell is fired.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy=0, shot_valid=0, no_target=0.
  - shot_idx=0, shot_row=0, shot_col=0.
  - All internal counters and best registers cleared.
- States: IDLE, SCAN, HOLD.
- IDLE:
  - start=1 at a rising edge: state->SCAN, idx=0, row=0, col=0.
  - Clear best_p_valid and best_a_valid.
  - busy goes high at that edge.
- SCAN, one cell per cycle at current idx:
  - eligible = !fired[idx].
  - par = ((row+col) bit0 == 0).
  - Candidate A (any eligible cell): replaces best_a if eligible and (!best_a_valid or density > best_a_den).
  - Candidate P (eligible and par): replaces best_p under the same rule.
  - Strictly-greater compare, so ties keep the lowest index.
  - Density 0 on an unfired cell is a valid candidate.
  - Row/col come from incrementing counters: col wraps 9->0 with row+1. No divider.
  - At idx==99 after evaluation: state->HOLD. Otherwise idx+1.
- Result selection on the HOLD entry edge:
  - If parity_en and best_p_valid: result = best_p.
  - Else if best_a_valid: result = best_a. This is the fallback when no parity cell is free.
  - Else: no_target=1, shot_idx=127, row=col=15.
  - shot_valid=1 from that edge.
- Latency: start sampled at edge 0; cells 0..99 evaluated at edges 1..100; shot_valid high after edge 100, i.e. exactly 100 cycles.
- HOLD:
  - Outputs stay stable until shot_valid&&shot_ready at an edge; then state->IDLE and shot_valid=0, busy=0.
  - shot_idx/row/col/no_target hold their values in IDLE.
  - shot_ready in the same cycle shot_valid first rises is legal and is accepted at the next edge.
- start while busy is ignored. A start in the same cycle as the handshake completes is also ignored; a new scan needs start in IDLE.
- density, fired and parity_en are not latched. The caller holds them stable from start through shot_valid. Changes mid-scan affect only cells not yet scanned, which is legal but undefined policy.
- rst_n asserted mid-SCAN or in HOLD: immediate return to reset values; no partial result emitted.
- Width rules:
  - Density compare is unsigned 6-bit; 63 is the maximum and compares normally.
  - idx is 7-bit and never exceeds 99 in SCAN.

Test Plan:
- Reset then idle: rst_n low mid-SCAN (cycle 40) -> busy=0, shot_valid=0 next cycle; subsequent start gives a clean 100-cycle scan.
- Single peak: all density 1, density[57]=20, fired=0, parity_en=0 -> shot_valid at cycle 100, shot_idx=57, row=5, col=7, no_target=0.
- Tie + fired skip:
  - Stimulus: density[12]=density[34]=30, fired[12]=1, rest 5, parity_en=0.
  - Required: shot_idx=34.
  - Then clear fired[12] and rescan: shot_idx=12 (lowest index on tie).
- Parity preference and fallback:
  - Stimulus: density[1]=40 (odd), density[0]=10, rest 0, parity_en=1.
  - Required: shot_idx=0.
  - Then fire all even cells: shot_idx=1.
- No target: fired all ones -> shot_valid=1, no_target=1, shot_idx=127, row=col=15.
- Handshake:
  - Stimulus: hold shot_ready=0 for 20 cycles and pulse start during HOLD.
  - Required: outputs stable, start ignored.
  - Then shot_ready=1: shot_valid drops next edge; a new start yields a second result 100 cycles later.
